// File: rtl/matmul_seq_if.sv
// rtl/matmul_seq_if.sv - single-port BRAM bus between matmul_seq (master) and user RAM (slave)
interface matmul_seq_if #(
  parameter int AW = 10,
  parameter int DW = 32
) ();
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata;

  modport master (
    output bram_en, bram_we, bram_addr, bram_wdata,
    input  bram_rdata
  );

  modport slave (
    input  bram_en, bram_we, bram_addr, bram_wdata,
    output bram_rdata
  );
endinterface

// File: rtl/matmul_seq.sv
// rtl/matmul_seq.sv - sequential N x N integer matrix multiply C = A*B over one BRAM port
// Optional saturating busy-cycle counter port cycle_cnt under MATMUL_SEQ_PERF_EN.
module matmul_seq #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          resetb,
  input  logic          start,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] base_c,
  output logic          busy,
  output logic          done,
  matmul_seq_if.master  bram
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [31:0]   cycle_cnt
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_ACC, S_WR, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_i, r_j, r_k;
  logic [DW-1:0] r_acc, r_a;
  logic [AW-1:0] r_base_a, r_base_b, r_base_c;
  logic [AW-1:0] w_addr_a, w_addr_b, w_addr_c;
  logic          w_start_ok, w_last_i, w_last_j, w_last_k;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_last_i   = (r_i == LAST);
  assign w_last_j   = (r_j == LAST);
  assign w_last_k   = (r_k == LAST);

  // Row-major addressing; AW-bit sums wrap silently.
  assign w_addr_a = r_base_a + AW'(r_i) * AW'(N) + AW'(r_k);
  assign w_addr_b = r_base_b + AW'(r_k) * AW'(N) + AW'(r_j);
  assign w_addr_c = r_base_c + AW'(r_i) * AW'(N) + AW'(r_j);

  always_ff @(posedge clock) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RD_A;
      S_RD_A:  w_next = S_RD_B;
      S_RD_B:  w_next = S_ACC;
      S_ACC:   w_next = w_last_k ? S_WR : S_RD_A;
      S_WR:    w_next = (w_last_i && w_last_j) ? S_DONE : S_RD_A;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    bram.bram_en   = 1'b0;
    bram.bram_we   = 1'b0;
    bram.bram_addr = '0;
    case (r_state)
      S_RD_A: begin
        busy           = 1'b1;
        bram.bram_en   = 1'b1;
        bram.bram_addr = w_addr_a;
      end
      S_RD_B: begin
        busy           = 1'b1;
        bram.bram_en   = 1'b1;
        bram.bram_addr = w_addr_b;
      end
      S_ACC:  busy = 1'b1;
      S_WR: begin
        busy           = 1'b1;
        bram.bram_en   = 1'b1;
        bram.bram_we   = 1'b1;
        bram.bram_addr = w_addr_c;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign bram.bram_wdata = r_acc;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start_ok) begin
          r_base_a <= base_a;
          r_base_b <= base_b;
          r_base_c <= base_c;
          r_i      <= '0;
          r_j      <= '0;
          r_k      <= '0;
          r_acc    <= '0;
        end
        // A[i][k] issued in RD_A arrives now.
        S_RD_B: r_a <= bram.bram_rdata;
        S_ACC: begin
          r_acc <= r_acc + r_a * bram.bram_rdata;
          if (!w_last_k) r_k <= r_k + 1'b1;
        end
        S_WR: begin
          r_acc <= '0;
          r_k   <= '0;
          if (w_last_j) begin
            r_j <= '0;
            if (!w_last_i) r_i <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] r_cycle_cnt;

  always_ff @(posedge clock) begin
    if (!resetb)                        r_cycle_cnt <= '0;
    else if (w_start_ok)                r_cycle_cnt <= '0;
    else if (busy && r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// tb/tb_matmul_seq.sv - randomized self-checking bench for matmul_seq against a behavioural model
// Build with MATMUL_SEQ_PERF_EN defined to also exercise cycle_cnt.
module tb_matmul_seq;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int P  = 3 * N + 1;
  localparam int T  = N * N * P;

  logic          clock = 1'b0;
  logic          resetb = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_a = '0, base_b = '0, base_c = '0;
  logic          busy, done;
`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0]   cycle_cnt;
`endif

  matmul_seq_if #(.AW(AW), .DW(DW)) u_if ();

  matmul_seq #(.N(N), .DW(DW), .AW(AW)) dut (
    .clock  (clock),
    .resetb (resetb),
    .start  (start),
    .base_a (base_a),
    .base_b (base_b),
    .base_c (base_c),
    .busy   (busy),
    .done   (done),
    .bram   (u_if)
`ifdef MATMUL_SEQ_PERF_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mc = 0;
  int busy_cnt = 0, done_cnt = 0, wr_cnt = 0, done_cyc = 0;
  bit chk_on = 1'b0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] a_m [N][N];
  logic [DW-1:0] exp_c [N][N];
  logic [AW-1:0] m_ba = '0, m_bb = '0, m_bc = '0;

  function automatic logic [AW-1:0] addr(input logic [AW-1:0] b, input int off);
    return b + AW'(off);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h mc=%0d t=%0t", nm, act, exp, mc, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // User RAM: one-cycle read latency; tb preload port used only while idle.
  always @(posedge clock) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    if (u_if.bram_en) begin
      if (u_if.bram_we) mem[u_if.bram_addr] <= u_if.bram_wdata;
      else              u_if.bram_rdata     <= mem[u_if.bram_addr];
    end
  end

  // Behavioural model: run phase counter mc (0 idle, 1..T busy, T+1 done) and the expected product.
  always @(posedge clock) begin : model
    logic [DW-1:0] s;
    if (!resetb) begin
      mc <= 0;
    end else if (mc == 0) begin
      if (start) begin
        mc   <= 1;
        m_ba <= base_a;
        m_bb <= base_b;
        m_bc <= base_c;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            s = '0;
            for (int k = 0; k < N; k++)
              s = s + mem[addr(base_a, i*N+k)] * mem[addr(base_b, k*N+j)];
            exp_c[i][j] = s;
          end
      end
    end else if (mc == T + 1) begin
      mc <= 0;
    end else begin
      mc <= mc + 1;
    end
  end

  always @(negedge clock) begin : compare
    int p, e, ii, jj, kk;
    bit xbusy, xdone, xen, xwe;
    logic [AW-1:0] xa;
    logic [DW-1:0] xd;
    if (chk_on) begin
      xbusy = (mc >= 1) && (mc <= T);
      xdone = (mc == T + 1);
      xen = 1'b0; xwe = 1'b0; xa = '0; xd = '0;
      if (xbusy) begin
        p = (mc - 1) % P; e = (mc - 1) / P; ii = e / N; jj = e % N;
        if (p == 3 * N) begin
          xen = 1'b1; xwe = 1'b1; xa = addr(m_bc, ii*N+jj); xd = exp_c[ii][jj];
        end else begin
          kk = p / 3;
          if (p % 3 == 0)      begin xen = 1'b1; xa = addr(m_ba, ii*N+kk); end
          else if (p % 3 == 1) begin xen = 1'b1; xa = addr(m_bb, kk*N+jj); end
        end
      end
      chk("busy", busy, xbusy);
      chk("done", done, xdone);
      chk("bram_en", u_if.bram_en, xen);
      if (xen) begin
        chk("bram_we", u_if.bram_we, xwe);
        chk("bram_addr", u_if.bram_addr, xa);
      end
      if (xwe) chk("bram_wdata", u_if.bram_wdata, xd);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (u_if.bram_en && u_if.bram_we) wr_cnt++;
    end
  end

  task automatic ld(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clock); #1;
    ld_we = 1'b0;
  endtask

  task automatic load_mats(input int mode, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input logic [AW-1:0] bc);
    logic [DW-1:0] v;
    base_a = ba; base_b = bb; base_c = bc;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        case (mode)
          0:       v = DW'(4*i + k);
          1:       v = $urandom | (((i + k) % 2 == 1) ? 32'h8000_0000 : 32'h0);
          2:       v = 32'h8000_0000;
          default: v = $urandom;
        endcase
        a_m[i][k] = v;
        ld(addr(ba, i*N+k), v);
      end
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) begin
        case (mode)
          0:       v = DW'(4*k + j + 1);
          1:       v = (k == j) ? 32'd1 : 32'd0;
          2:       v = 32'h8000_0000;
          default: v = $urandom;
        endcase
        ld(addr(bb, k*N+j), v);
      end
    for (int e = 0; e < N*N; e++) ld(addr(bc, e), $urandom | 32'h1);
  endtask

  task automatic start_run();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_mc(input int c);
    int n;
    n = 0;
    while (mc != c && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("wait_bound", (mc == c), 1'b1);
  endtask

  task automatic run_and_check(input string nm);
    int d0, b0, w0, t0;
    d0 = done_cnt; b0 = busy_cnt; w0 = wr_cnt;
    start_run();
    t0 = cyc - 1;
`ifdef MATMUL_SEQ_PERF_EN
    chk("cycle_cnt_cleared", cycle_cnt, 0);
`endif
    wait_mc(0);
    chk("done_cycle", done_cyc - t0, 209);
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_cycles", busy_cnt - b0, 208);
    chk("write_count", wr_cnt - w0, 16);
`ifdef MATMUL_SEQ_PERF_EN
    chk("cycle_cnt_final", cycle_cnt, 208);
`endif
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk(nm, mem[addr(m_bc, i*N+j)], exp_c[i][j]);
  endtask

  initial begin
    int d0;
    resetb = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en", u_if.bram_en, 0);
    chk("rst_we", u_if.bram_we, 0);
    chk("rst_addr", u_if.bram_addr, 0);
    chk("rst_wdata", u_if.bram_wdata, 0);
`ifdef MATMUL_SEQ_PERF_EN
    chk("rst_cycle_cnt", cycle_cnt, 0);
`endif
    @(posedge clock); #1;
    resetb = 1'b1;
    chk_on = 1'b1;

    load_mats(0, 10'h000, 10'h010, 10'h020);
    run_and_check("basic_c");
    chk("basic_c00", mem[10'h020], 32'h3E);
    chk("basic_c01", mem[10'h021], 32'h44);
    chk("basic_c02", mem[10'h022], 32'h4A);
    chk("basic_c03", mem[10'h023], 32'h50);
    chk("basic_c10", mem[10'h024], 32'hAE);
    run_and_check("basic_rerun");

    load_mats(1, 10'h100, 10'h140, 10'h020);
    run_and_check("ident_model");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk("ident_eq_a", mem[addr(10'h020, i*N+j)], a_m[i][j]);

    load_mats(2, 10'h080, 10'h0C0, 10'h200);
    run_and_check("ovf_model");
    for (int e = 0; e < N*N; e++) chk("ovf_zero", mem[addr(10'h200, e)], 0);

    load_mats(3, 10'h100, 10'h180, 10'h240);
    d0 = done_cnt;
    start_run();
    wait_mc(5);   start_run();
    wait_mc(100); start_run();
    wait_mc(209); start_run();
    chk("ignored_start_done", done_cnt - d0, 1);
    run_and_check("restart_c");

    load_mats(3, 10'h100, 10'h180, 10'h240);
    d0 = done_cnt;
    start_run();
    wait_mc(50);
    resetb = 1'b0;
    @(posedge clock); #1;
    resetb = 1'b1;
    @(negedge clock);
    chk("abort_busy", busy, 0);
    chk("abort_en", u_if.bram_en, 0);
    repeat (250) @(posedge clock);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    load_mats(3, 10'h140, 10'h1C0, 10'h280);
    run_and_check("after_abort_c");

    for (int r = 0; r < 3; r++) begin
      load_mats(3, 10'h100 + AW'($urandom_range(0, 31)), 10'h200 + AW'($urandom_range(0, 31)),
                (r == 0) ? 10'h3F8 : 10'h300 + AW'($urandom_range(0, 31)));
      run_and_check("random_c");
    end

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
